// File: rtl/cp0_exc_unit.sv
// CP0 exception unit: BadVAddr/Count/Compare/Status/Cause/EPC registers,
// prioritised exception entry, ERET return, timer interrupt and MFC0/MTC0 access.
module cp0_exc_unit #(
   parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
   parameter logic        BEV_RESET  = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        commit_valid,
   input  logic [31:0] commit_pc,
   input  logic        commit_bd,
   input  logic [31:0] commit_badaddr,
   input  logic        exc_adel_if,
   input  logic        exc_ri,
   input  logic        exc_ov,
   input  logic        exc_sys,
   input  logic        exc_bp,
   input  logic        exc_adel,
   input  logic        exc_ades,
   input  logic        eret,
   input  logic [5:0]  hw_int,
   input  logic        mtc0_we,
   input  logic [4:0]  c0_addr,
   input  logic [31:0] c0_wdata,
   output logic [31:0] c0_rdata,
   output logic        flush,
   output logic [31:0] flush_pc,
   output logic        int_pending
);

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_SYS  = 5'd8,
      EXC_BP   = 5'd9,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   typedef enum logic [1:0] {
      BAD_HOLD,
      BAD_PC,
      BAD_DATA
   } bad_src_e;

   logic [31:0] badvaddr;
   logic [31:0] count;
   logic [31:0] compare;
   logic [31:0] epc;
   logic        count_tog;
   logic [7:0]  im;
   logic        exl;
   logic        ie;
   logic        cause_bd;
   logic        cause_ti;
   logic [5:0]  ip_hw;
   logic [1:0]  ip_sw;
   exc_code_e   exc_code;

   logic [31:0] status_word;
   logic [31:0] cause_word;
   logic        exc_any;
   exc_code_e   exc_sel;
   bad_src_e    bad_src;
   logic        exc_taken;
   logic        eret_take;
   logic        c0_wr;
   logic        count_wr;
   logic        compare_wr;
   logic        status_wr;
   logic        cause_wr;
   logic        epc_wr;

   assign status_word = {9'b0, BEV_RESET, 6'b0, im, 6'b0, exl, ie};
   assign cause_word  = {cause_bd, cause_ti, 14'b0, ip_hw, ip_sw, 1'b0, exc_code, 2'b0};
   assign int_pending = ie & ~exl & (|({ip_hw, ip_sw} & im));

   always_comb begin
      exc_any = 1'b1;
      exc_sel = EXC_INT;
      bad_src = BAD_HOLD;
      if (int_pending) begin
         exc_sel = EXC_INT;
      end else if (exc_adel_if) begin
         exc_sel = EXC_ADEL;
         bad_src = BAD_PC;
      end else if (exc_ri) begin
         exc_sel = EXC_RI;
      end else if (exc_ov) begin
         exc_sel = EXC_OV;
      end else if (exc_sys) begin
         exc_sel = EXC_SYS;
      end else if (exc_bp) begin
         exc_sel = EXC_BP;
      end else if (exc_adel) begin
         exc_sel = EXC_ADEL;
         bad_src = BAD_DATA;
      end else if (exc_ades) begin
         exc_sel = EXC_ADES;
         bad_src = BAD_DATA;
      end else begin
         exc_any = 1'b0;
      end
   end

   assign exc_taken  = commit_valid & exc_any;
   assign eret_take  = commit_valid & eret & ~exc_taken;
   assign c0_wr      = commit_valid & mtc0_we & ~exc_taken;
   assign count_wr   = c0_wr && (c0_addr == 5'd9);
   assign compare_wr = c0_wr && (c0_addr == 5'd11);
   assign status_wr  = c0_wr && (c0_addr == 5'd12);
   assign cause_wr   = c0_wr && (c0_addr == 5'd13);
   assign epc_wr     = c0_wr && (c0_addr == 5'd14);

   always_comb begin
      case (c0_addr)
         5'd8:    c0_rdata = badvaddr;
         5'd9:    c0_rdata = count;
         5'd11:   c0_rdata = compare;
         5'd12:   c0_rdata = status_word;
         5'd13:   c0_rdata = cause_word;
         5'd14:   c0_rdata = epc;
         default: c0_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         badvaddr  <= '0;
         count     <= '0;
         compare   <= '0;
         epc       <= '0;
         count_tog <= 1'b0;
         im        <= '0;
         exl       <= 1'b1;
         ie        <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ti  <= 1'b0;
         ip_hw     <= '0;
         ip_sw     <= '0;
         exc_code  <= EXC_INT;
         flush     <= 1'b0;
         flush_pc  <= '0;
      end else begin
         count_tog <= ~count_tog;
         if (count_wr)
            count <= c0_wdata;
         else if (count_tog)
            count <= count + 32'd1;

         // Compare write clears TI even when this edge would also see a match
         if (compare_wr) begin
            compare  <= c0_wdata;
            cause_ti <= 1'b0;
         end else if (count == compare) begin
            cause_ti <= 1'b1;
         end

         ip_hw <= {hw_int[5] | cause_ti, hw_int[4:0]};

         if (status_wr) begin
            im  <= c0_wdata[15:8];
            exl <= c0_wdata[1];
            ie  <= c0_wdata[0];
         end
         if (cause_wr)
            ip_sw <= c0_wdata[9:8];
         if (epc_wr)
            epc <= c0_wdata;

         flush <= exc_taken | eret_take;
         if (exc_taken) begin
            exl      <= 1'b1;
            exc_code <= exc_sel;
            flush_pc <= EXC_VECTOR;
            if (!exl) begin
               epc      <= commit_bd ? commit_pc - 32'd4 : commit_pc;
               cause_bd <= commit_bd;
            end
            case (bad_src)
               BAD_PC:   badvaddr <= commit_pc;
               BAD_DATA: badvaddr <= commit_badaddr;
               default:  ;
            endcase
         end else if (eret_take) begin
            exl      <= 1'b0;
            flush_pc <= epc;
         end
      end
   end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: directed scenarios plus a randomized run checked
// against a word-level register model.
module tb_cp0_exc_unit;

   localparam logic [31:0] VEC = 32'hbfc00380;

   logic        clk;
   logic        resetn;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic        commit_bd;
   logic [31:0] commit_badaddr;
   logic        exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel, exc_ades, eret;
   logic [5:0]  hw_int;
   logic        mtc0_we;
   logic [4:0]  c0_addr;
   logic [31:0] c0_wdata;
   logic [31:0] c0_rdata;
   logic        flush;
   logic [31:0] flush_pc;
   logic        int_pending;

   int errors = 0;
   int checks = 0;

   // reference model state: one 32-bit word per CP0 register number
   logic [31:0] m [32];
   logic [31:0] nm [32];
   logic        m_tog;
   logic        m_flush;
   logic [31:0] m_fpc;

   cp0_exc_unit #(.EXC_VECTOR(VEC), .BEV_RESET(1'b1)) dut (
      .clk(clk), .resetn(resetn), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_bd(commit_bd), .commit_badaddr(commit_badaddr), .exc_adel_if(exc_adel_if),
      .exc_ri(exc_ri), .exc_ov(exc_ov), .exc_sys(exc_sys), .exc_bp(exc_bp),
      .exc_adel(exc_adel), .exc_ades(exc_ades), .eret(eret), .hw_int(hw_int),
      .mtc0_we(mtc0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_rdata(c0_rdata),
      .flush(flush), .flush_pc(flush_pc), .int_pending(int_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      commit_valid = 0; commit_pc = '0; commit_bd = 0; commit_badaddr = '0;
      exc_adel_if = 0; exc_ri = 0; exc_ov = 0; exc_sys = 0; exc_bp = 0;
      exc_adel = 0; exc_ades = 0; eret = 0; hw_int = '0;
      mtc0_we = 0; c0_addr = '0; c0_wdata = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      resetn = 0;
      tick();
      tick();
      resetn = 1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      idle();
      commit_valid = 1; mtc0_we = 1; c0_addr = a; c0_wdata = d;
      tick();
      idle();
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] v);
      c0_addr = a;
      #1;
      v = c0_rdata;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      logic [31:0] exp_v [6];
      logic [4:0]  addrs [6];
      addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
      exp_v = '{32'h0, 32'h0, 32'h0, 32'h00400002, 32'h0, 32'h0};
      idle();
      resetn = 0;
      tick();
      tick();
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
      checks++; if (flush_pc !== 32'h0) begin errors++; $display("FAIL reset_flush_pc got=%h exp=0", flush_pc); end
      checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL reset_int got=%b exp=0", int_pending); end
      for (int i = 0; i < 6; i++) begin
         rd(addrs[i], v);
         checks++;
         if (v !== exp_v[i]) begin errors++; $display("FAIL reset_reg%0d got=%h exp=%h", addrs[i], v, exp_v[i]); end
      end
      rd(5'd31, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL unimpl_read got=%h exp=0", v); end
      // an exception committing while reset is asserted must not flush
      resetn = 1;
      tick();
      mtc0(5'd12, 32'h0);
      commit_valid = 1; commit_pc = 32'h80000040; exc_sys = 1; resetn = 0;
      tick();
      idle();
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_mid_exc_flush got=%b exp=0", flush); end
      rd(5'd12, v);
      checks++; if (v !== 32'h00400002) begin errors++; $display("FAIL reset_mid_exc_status got=%h exp=00400002", v); end
      resetn = 1;
   endtask

   task automatic test_syscall();
      logic [31:0] v;
      do_reset();
      mtc0(5'd12, 32'h0);
      commit_valid = 1; commit_pc = 32'hbfc01000; exc_sys = 1;
      tick();
      idle();
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL sys_flush got=%b exp=1", flush); end
      checks++; if (flush_pc !== VEC) begin errors++; $display("FAIL sys_flush_pc got=%h exp=%h", flush_pc, VEC); end
      rd(5'd14, v);
      checks++; if (v !== 32'hbfc01000) begin errors++; $display("FAIL sys_epc got=%h exp=bfc01000", v); end
      rd(5'd13, v);
      checks++; if (v[6:2] !== 5'd8) begin errors++; $display("FAIL sys_exccode got=%0d exp=8", v[6:2]); end
      rd(5'd12, v);
      checks++; if (v[1] !== 1'b1) begin errors++; $display("FAIL sys_exl got=%b exp=1", v[1]); end
      tick();
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL sys_flush_one_cycle got=%b exp=0", flush); end
   endtask

   task automatic test_ri_ov_bd();
      logic [31:0] v;
      mtc0(5'd12, 32'h0);
      // the MTC0 to EPC riding with the exception must be suppressed
      commit_valid = 1; commit_pc = 32'h80000104; commit_bd = 1; exc_ri = 1; exc_ov = 1;
      mtc0_we = 1; c0_addr = 5'd14; c0_wdata = 32'hdeadbeef;
      tick();
      idle();
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL riov_flush got=%b exp=1", flush); end
      rd(5'd13, v);
      checks++; if (v[6:2] !== 5'd10) begin errors++; $display("FAIL riov_exccode got=%0d exp=10", v[6:2]); end
      checks++; if (v[31] !== 1'b1) begin errors++; $display("FAIL riov_bd got=%b exp=1", v[31]); end
      rd(5'd14, v);
      checks++; if (v !== 32'h80000100) begin errors++; $display("FAIL riov_epc got=%h exp=80000100", v); end
   endtask

   task automatic test_exl_bp();
      logic [31:0] v;
      commit_valid = 1; commit_pc = 32'h80002000; exc_bp = 1;
      tick();
      idle();
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL bp_flush got=%b exp=1", flush); end
      rd(5'd13, v);
      checks++; if (v[6:2] !== 5'd9) begin errors++; $display("FAIL bp_exccode got=%0d exp=9", v[6:2]); end
      checks++; if (v[31] !== 1'b1) begin errors++; $display("FAIL bp_bd_hold got=%b exp=1", v[31]); end
      rd(5'd14, v);
      checks++; if (v !== 32'h80000100) begin errors++; $display("FAIL bp_epc_hold got=%h exp=80000100", v); end
   endtask

   task automatic test_timer_int();
      logic [31:0] v;
      int ti_cycle;
      bit got;
      do_reset();
      mtc0(5'd11, 32'd20);
      mtc0(5'd9, 32'd10);
      mtc0(5'd12, 32'h00008001);
      commit_valid = 1; commit_pc = 32'h80000200;
      ti_cycle = -1;
      got = 0;
      for (int i = 0; i < 80 && !got; i++) begin
         rd(5'd13, v);
         if (v[30] && ti_cycle < 0) ti_cycle = i;
         tick();
         if (flush) got = 1;
      end
      idle();
      checks++; if (!got) begin errors++; $display("FAIL timer_int_taken got=0 exp=1 within 80 cycles"); end
      checks++; if (ti_cycle < 19 || ti_cycle > 20) begin errors++; $display("FAIL timer_ti_delay got=%0d exp=19..20", ti_cycle); end
      checks++; if (flush_pc !== VEC) begin errors++; $display("FAIL timer_flush_pc got=%h exp=%h", flush_pc, VEC); end
      rd(5'd13, v);
      checks++; if (v[6:2] !== 5'd0) begin errors++; $display("FAIL timer_exccode got=%0d exp=0", v[6:2]); end
      checks++; if (v[30] !== 1'b1 || v[15] !== 1'b1) begin errors++; $display("FAIL timer_ti_ip7 got=%b%b exp=11", v[30], v[15]); end
      rd(5'd14, v);
      checks++; if (v !== 32'h80000200) begin errors++; $display("FAIL timer_epc got=%h exp=80000200", v); end
      mtc0(5'd11, 32'd100);
      rd(5'd13, v);
      checks++; if (v[30] !== 1'b0) begin errors++; $display("FAIL timer_ti_clear got=%b exp=0", v[30]); end
      // Compare write on the very edge where Count==Compare: the clear wins
      mtc0(5'd11, 32'd40);
      mtc0(5'd9, 32'd40);
      mtc0(5'd11, 32'd99);
      rd(5'd13, v);
      checks++; if (v[30] !== 1'b0) begin errors++; $display("FAIL timer_clear_wins got=%b exp=0", v[30]); end
   endtask

   task automatic test_eret();
      logic [31:0] v;
      do_reset();
      mtc0(5'd14, 32'h80001000);
      commit_valid = 1; commit_pc = 32'h80000500; eret = 1;
      tick();
      idle();
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL eret_flush got=%b exp=1", flush); end
      checks++; if (flush_pc !== 32'h80001000) begin errors++; $display("FAIL eret_flush_pc got=%h exp=80001000", flush_pc); end
      rd(5'd12, v);
      checks++; if (v[1] !== 1'b0) begin errors++; $display("FAIL eret_exl got=%b exp=0", v[1]); end
      commit_valid = 1; commit_pc = 32'h80003000; eret = 1; exc_ades = 1; commit_badaddr = 32'h00001236;
      tick();
      idle();
      checks++; if (flush_pc !== VEC) begin errors++; $display("FAIL eret_ades_flush_pc got=%h exp=%h", flush_pc, VEC); end
      rd(5'd13, v);
      checks++; if (v[6:2] !== 5'd5) begin errors++; $display("FAIL eret_ades_exccode got=%0d exp=5", v[6:2]); end
      rd(5'd8, v);
      checks++; if (v !== 32'h00001236) begin errors++; $display("FAIL eret_ades_badvaddr got=%h exp=00001236", v); end
      rd(5'd12, v);
      checks++; if (v[1] !== 1'b1) begin errors++; $display("FAIL eret_ades_exl got=%b exp=1", v[1]); end
      rd(5'd14, v);
      checks++; if (v !== 32'h80003000) begin errors++; $display("FAIL eret_ades_epc got=%h exp=80003000", v); end
   endtask

   task automatic test_adel_if_wrap();
      logic [31:0] v;
      do_reset();
      commit_valid = 1; commit_pc = 32'h80000003; exc_adel_if = 1; commit_badaddr = 32'h12345678;
      tick();
      idle();
      rd(5'd8, v);
      checks++; if (v !== 32'h80000003) begin errors++; $display("FAIL adelif_badvaddr got=%h exp=80000003", v); end
      rd(5'd13, v);
      checks++; if (v[6:2] !== 5'd4) begin errors++; $display("FAIL adelif_exccode got=%0d exp=4", v[6:2]); end
      mtc0(5'd9, 32'hffffffff);
      rd(5'd9, v);
      checks++; if (v !== 32'hffffffff) begin errors++; $display("FAIL count_write got=%h exp=ffffffff", v); end
      tick();
      tick();
      rd(5'd9, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL count_wrap got=%h exp=0", v); end
   endtask

   task automatic test_random();
      logic [31:0] v;
      logic [31:0] wd;
      logic [4:0]  a;
      logic        exp_int;
      logic        flg [8];
      int          codes [8];
      int          bsel [8];
      int          alist [7];
      int          win;
      bit          wr;
      codes = '{0, 4, 10, 12, 8, 9, 4, 5};
      bsel  = '{0, 1, 0, 0, 0, 0, 2, 2};
      alist = '{8, 9, 11, 12, 13, 14, 0};
      do_reset();
      for (int r = 0; r < 32; r++) m[r] = '0;
      m[12] = 32'h00400002;
      m_tog = 0; m_flush = 0; m_fpc = '0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         commit_valid   = ($urandom_range(0, 3) != 0);
         commit_pc      = $urandom;
         commit_bd      = $urandom_range(0, 1);
         commit_badaddr = $urandom;
         exc_adel_if = ($urandom_range(0, 15) == 0);
         exc_ri      = ($urandom_range(0, 15) == 0);
         exc_ov      = ($urandom_range(0, 15) == 0);
         exc_sys     = ($urandom_range(0, 15) == 0);
         exc_bp      = ($urandom_range(0, 15) == 0);
         exc_adel    = ($urandom_range(0, 15) == 0);
         exc_ades    = ($urandom_range(0, 15) == 0);
         eret        = ($urandom_range(0, 7) == 0);
         hw_int      = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
         mtc0_we     = ($urandom_range(0, 2) == 0);
         a = 5'(alist[$urandom_range(0, 6)]);
         if (a == 5'd0) a = 5'($urandom_range(0, 31));
         wd = (a == 5'd9 || a == 5'd11) ? 32'($urandom_range(0, 40)) : $urandom;
         c0_addr = a; c0_wdata = wd;
         #1;
         exp_int = m[12][0] && !m[12][1] && ((m[13][15:8] & m[12][15:8]) != 8'd0);
         v = (a inside {5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14}) ? m[a] : 32'h0;
         checks++; if (c0_rdata !== v) begin errors++; $display("FAIL rand_rdata cyc=%0d addr=%0d got=%h exp=%h", cyc, a, c0_rdata, v); end
         checks++; if (int_pending !== exp_int) begin errors++; $display("FAIL rand_int cyc=%0d got=%b exp=%b", cyc, int_pending, exp_int); end

         flg = '{exp_int, exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel, exc_ades};
         win = -1;
         for (int k = 7; k >= 0; k--) if (flg[k]) win = k;
         if (!commit_valid) win = -1;
         wr = mtc0_we && commit_valid && (win < 0);
         nm = m;
         if (wr) begin
            case (a)
               5'd9:  nm[9] = wd;
               5'd11: nm[11] = wd;
               5'd12: nm[12] = (wd & 32'h0000ff03) | 32'h00400000;
               5'd13: nm[13] = (m[13] & ~32'h300) | (wd & 32'h300);
               5'd14: nm[14] = wd;
               default: ;
            endcase
         end
         if (!(wr && a == 5'd9) && m_tog) nm[9] = m[9] + 32'd1;
         m_tog = !m_tog;
         if (wr && a == 5'd11) nm[13][30] = 1'b0;
         else if (m[9] == m[11]) nm[13][30] = 1'b1;
         nm[13][15:10] = {hw_int[5] | m[13][30], hw_int[4:0]};
         if (win >= 0) begin
            nm[12][1] = 1'b1;
            nm[13][6:2] = 5'(codes[win]);
            if (!m[12][1]) begin
               nm[14] = commit_bd ? commit_pc - 32'd4 : commit_pc;
               nm[13][31] = commit_bd;
            end
            if (bsel[win] == 1) nm[8] = commit_pc;
            else if (bsel[win] == 2) nm[8] = commit_badaddr;
            m_flush = 1; m_fpc = VEC;
         end else if (commit_valid && eret) begin
            nm[12][1] = 1'b0;
            m_flush = 1; m_fpc = m[14];
         end else begin
            m_flush = 0;
         end
         m = nm;
         tick();
         checks++; if (flush !== m_flush) begin errors++; $display("FAIL rand_flush cyc=%0d got=%b exp=%b", cyc, flush, m_flush); end
         if (m_flush) begin
            checks++; if (flush_pc !== m_fpc) begin errors++; $display("FAIL rand_flush_pc cyc=%0d got=%h exp=%h", cyc, flush_pc, m_fpc); end
         end
      end
      idle();
   endtask

   initial begin
      idle();
      resetn = 0;
      test_reset();
      test_syscall();
      test_ri_ov_bd();
      test_exl_bp();
      test_timer_int();
      test_eret();
      test_adel_if_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
